// File: rtl/adsr_pkg.sv
// Shared state encoding and saturating arithmetic for the ADSR envelope generator.
package adsr_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } adsr_state_e;

  // Add or subtract two width-bit unsigned values, clamping to [0, 2^width-1].
  function automatic logic [31:0] sat_addsub(input int unsigned width, input logic [31:0] a,
                                             input logic [31:0] b, input logic sub);
    logic [32:0] max_v;
    logic [32:0] res;
    max_v = (33'd1 << width) - 33'd1;
    if (sub) begin
      res = (b > a) ? 33'd0 : ({1'b0, a} - {1'b0, b});
    end else begin
      res = {1'b0, a} + {1'b0, b};
      if (res > max_v) res = max_v;
    end
    return res[31:0];
  endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Sample-path bundle between the note source, the envelope stage and the mixer.
interface adsr_envelope_if #(
  parameter int unsigned SAMPLE_W = 16
) ();
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_in_valid;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_out_valid;

  modport master (
    output sample_in, sample_in_valid,
    input  sample_out, sample_out_valid
  );

  modport slave (
    input  sample_in, sample_in_valid,
    output sample_out, sample_out_valid
  );
endinterface

// File: rtl/env_gain_mul.sv
// Registered signed-sample by unsigned-gain multiply; output scaled back by 2^ENV_W.
module env_gain_mul #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned ENV_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       valid_i,
  input  logic [ENV_W-1:0]           env_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       valid_o
);
  localparam int unsigned ProdW = SAMPLE_W + ENV_W + 1;

  logic signed [ProdW-1:0]    smp_ext, gain_ext, product;
  logic signed [SAMPLE_W-1:0] sample_d, sample_q;
  logic                       valid_d, valid_q;

  always_comb begin
    smp_ext  = ProdW'(sample_i);
    gain_ext = ProdW'({1'b0, env_i});
    product  = smp_ext * gain_ext;
    // Gain never exceeds (2^ENV_W-1)/2^ENV_W, so the shifted product always fits.
    sample_d = SAMPLE_W'(product >>> ENV_W);
    valid_d  = valid_i && en_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;
endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gain FSM plus a one-cycle gain stage on the sample path.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned ENV_W    = 8,
  parameter int unsigned RATE_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                beat,
  input  logic                note_start,
  input  logic                note_release,
  input  logic [RATE_W-1:0]   attack_step,
  input  logic [RATE_W-1:0]   decay_step,
  input  logic [RATE_W-1:0]   release_step,
  input  logic [ENV_W-1:0]    sustain_level,
  adsr_envelope_if.slave      smp,
  output logic [ENV_W-1:0]    env_level,
  output logic [StateW-1:0]   env_state,
  output logic                busy
);
  localparam logic [ENV_W-1:0] EnvMax = '1;

  adsr_state_e      state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic             busy_q;
  logic [ENV_W-1:0] att_sum, dec_diff, rel_diff;

  assign att_sum  = ENV_W'(sat_addsub(ENV_W, 32'(env_q), 32'(attack_step), 1'b0));
  assign dec_diff = ENV_W'(sat_addsub(ENV_W, 32'(env_q), 32'(decay_step), 1'b1));
  assign rel_diff = ENV_W'(sat_addsub(ENV_W, 32'(env_q), 32'(release_step), 1'b1));

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (!play_enable) begin
      state_d = StIdle;
      env_d   = '0;
    end else if (note_start) begin
      // Legato: keep the current gain unless starting from silence.
      state_d = StAttack;
      if (state_q == StIdle) env_d = '0;
    end else if (note_release &&
                 (state_q == StAttack || state_q == StDecay || state_q == StSustain)) begin
      state_d = StRelease;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAttack: begin
          if (beat) begin
            env_d = (attack_step == '0) ? EnvMax : att_sum;
            if (attack_step == '0 || att_sum == EnvMax) state_d = StDecay;
          end
        end
        StDecay: begin
          if (beat) begin
            if (decay_step == '0 || env_q < sustain_level || dec_diff <= sustain_level) begin
              env_d   = sustain_level;
              state_d = StSustain;
            end else begin
              env_d = dec_diff;
            end
          end
        end
        StSustain: env_d = sustain_level;
        StRelease: begin
          if (beat) begin
            env_d = (release_step == '0) ? '0 : rel_diff;
            if (release_step == '0 || rel_diff == '0) state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          env_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      env_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign env_level = env_q;
  assign env_state = state_q;
  assign busy      = busy_q;

  env_gain_mul #(
    .SAMPLE_W(SAMPLE_W),
    .ENV_W   (ENV_W)
  ) u_gain (
    .clk     (clk),
    .reset   (reset),
    .en_i    (play_enable),
    .sample_i(smp.sample_in),
    .valid_i (smp.sample_in_valid),
    .env_i   (env_q),
    .sample_o(smp.sample_out),
    .valid_o (smp.sample_out_valid)
  );
endmodule

// File: tb/tb_adsr_envelope.sv
// Scenario bench for adsr_envelope: sample path scored through a queue, envelope against a tracked model.
module tb_adsr_envelope;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_enable = 1'b1;
  logic       beat = 1'b0;
  logic       note_start = 1'b0;
  logic       note_release = 1'b0;
  logic [3:0] attack_step = 4'd15;
  logic [3:0] decay_step = 4'd5;
  logic [3:0] release_step = 4'd1;
  logic [7:0] sustain_level = 8'd128;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       busy;

  adsr_envelope_if #(.SAMPLE_W(16)) smp_if ();

  adsr_envelope #(
    .SAMPLE_W(16),
    .ENV_W   (8),
    .RATE_W  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_enable  (play_enable),
    .beat         (beat),
    .note_start   (note_start),
    .note_release (note_release),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .release_step (release_step),
    .sustain_level(sustain_level),
    .smp          (smp_if),
    .env_level    (env_level),
    .env_state    (env_state),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  longint       sb_q[$];
  int unsigned  exp_env = 0;
  int unsigned  exp_state = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint gain_model(input longint s, input int unsigned e);
    longint p;
    p = s * longint'(e);
    return p >>> 8;
  endfunction

  // One clock: drive a sample, push its expected result, then score the output.
  task automatic step(input bit force_v = 1'b0, input logic signed [15:0] fs = 16'sd0);
    bit exp_v;
    if (force_v) begin
      smp_if.sample_in       = fs;
      smp_if.sample_in_valid = 1'b1;
    end else begin
      smp_if.sample_in       = 16'($urandom);
      smp_if.sample_in_valid = 1'($urandom_range(0, 1));
    end
    exp_v = smp_if.sample_in_valid && play_enable && !reset;
    if (exp_v) sb_q.push_back(gain_model(longint'(smp_if.sample_in), exp_env));
    @(posedge clk);
    #1;
    note_start   = 1'b0;
    note_release = 1'b0;
    beat         = 1'b0;
    check_eq("out_valid", longint'(smp_if.sample_out_valid), longint'(exp_v));
    if (smp_if.sample_out_valid) begin
      if (sb_q.size() == 0) check_eq("sb_underflow", 1, 0);
      else check_eq("out_data", longint'(smp_if.sample_out), sb_q.pop_front());
    end
  endtask

  task automatic chk(input string tag);
    check_eq({tag, "_env"}, longint'(env_level), longint'(exp_env));
    check_eq({tag, "_state"}, longint'(env_state), longint'(exp_state));
    check_eq({tag, "_busy"}, longint'(busy), longint'(exp_state != 0));
  endtask

  // Beat pulse followed by three quiet clocks, envelope held between beats.
  task automatic beat4(input int unsigned new_env, input int unsigned new_state,
                       input string tag);
    beat = 1'b1;
    step();
    exp_env   = new_env;
    exp_state = new_state;
    chk(tag);
    repeat (3) begin
      step();
      chk({tag, "_hold"});
    end
  endtask

  initial begin
    int unsigned v;
    smp_if.sample_in       = '0;
    smp_if.sample_in_valid = 1'b0;

    // Reset values
    step(1'b1, 16'sh1234);
    exp_env = 0; exp_state = 0;
    chk("reset");
    check_eq("reset_out", longint'(smp_if.sample_out), 0);
    reset = 1'b0;

    // Attack 15/beat to 255 on the 17th beat, then decay 5/beat to sustain 128
    note_start = 1'b1;
    step();
    exp_state = 1; exp_env = 0;
    chk("start");
    for (int k = 1; k <= 17; k++) begin
      v = (15 * k > 255) ? 255 : 15 * k;
      beat4(v, (v == 255) ? 2 : 1, "attack");
    end
    step(1'b1, -16'sd32768);
    check_eq("gain_full", longint'(smp_if.sample_out), -32640);
    for (int k = 1; k <= 26; k++) begin
      v = 255 - 5 * k;
      if (v <= 128) beat4(128, 3, "decay");
      else beat4(v, 2, "decay");
    end

    // Sustain gain math and live sustain level
    step(1'b1, 16'sh4000);
    check_eq("gain_half", longint'(smp_if.sample_out), 16'sh2000);
    sustain_level = 8'd100;
    step();
    exp_env = 100;
    chk("sustain_live");
    sustain_level = 8'd128;
    step();
    exp_env = 128;
    chk("sustain_back");

    // Release 1/beat from 128 down to IDLE
    note_release = 1'b1;
    step();
    exp_state = 4;
    chk("release");
    for (int k = 1; k <= 128; k++) begin
      v = 128 - k;
      beat4(v, (v == 0) ? 0 : 4, "rel");
    end
    note_release = 1'b1;
    step();
    chk("idle_rel_ignored");
    repeat (4) begin
      step(1'b1, 16'(-$urandom_range(1, 30000)));
      chk("idle_pass");
    end

    // All steps zero: one phase per beat
    attack_step = 4'd0; decay_step = 4'd0; release_step = 4'd0; sustain_level = 8'd60;
    note_start = 1'b1;
    step();
    exp_state = 1; exp_env = 0;
    chk("zero_start");
    beat4(255, 2, "zero_att");
    beat4(60, 3, "zero_dec");

    // Release at 60, retrigger coincident with beat: no step, then +10
    note_release = 1'b1;
    step();
    exp_state = 4;
    chk("rel60");
    attack_step = 4'd10;
    note_start  = 1'b1;
    beat        = 1'b1;
    step();
    exp_state = 1;
    chk("retrig");
    beat4(70, 1, "retrig_att");

    // Start and release together: start wins
    note_start = 1'b1; note_release = 1'b1;
    step();
    chk("collide");

    // play_enable low mid-attack
    play_enable = 1'b0;
    step(1'b1, 16'sh7fff);
    exp_env = 0; exp_state = 0;
    chk("play_off");
    play_enable = 1'b1;
    step();
    chk("play_back");

    // Reset mid-decay
    attack_step = 4'd0;
    note_start = 1'b1;
    step();
    exp_state = 1;
    beat4(255, 2, "pre_rst");
    reset = 1'b1;
    step(1'b1, 16'sh1111);
    exp_env = 0; exp_state = 0;
    chk("rst_decay");
    check_eq("rst_out", longint'(smp_if.sample_out), 0);
    reset = 1'b0;
    step();
    chk("rst_after");

    check_eq("sb_empty", longint'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
